// File: rtl/dpram_pkg.sv
// Shared constants for the byte-enable dual-port RAM wrapper: collision policy
// encoding and the init-engine state type.
package dpram_pkg;

    localparam int unsigned COLL_RD_FIRST = 0;
    localparam int unsigned COLL_WR_FIRST = 1;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } init_state_e;

endpackage

// File: rtl/dpram_rd_pipe.sv
// Free-running read data/valid delay line. Data stages only load when their
// incoming valid is set, so the last stage holds its value between reads.
module dpram_rd_pipe #(
    parameter int unsigned DW      = 64,
    parameter int unsigned N_DELAY = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          vld_i,
    input  logic [DW-1:0] dat_i,
    output logic          vld_o,
    output logic [DW-1:0] dat_o
);

    if (N_DELAY < 1) begin : g_bad_delay
        $error("dpram_rd_pipe: N_DELAY must be >= 1");
    end

    logic [N_DELAY-1:0] vld_q;
    logic [DW-1:0]      dat_q [N_DELAY];
    logic [N_DELAY:0]   vld_chain;
    logic [DW-1:0]      dat_chain [N_DELAY+1];

    always_comb begin
        vld_chain    = {vld_q, vld_i};
        dat_chain[0] = dat_i;
        for (int i = 0; i < N_DELAY; i++) begin
            dat_chain[i+1] = dat_q[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            for (int i = 0; i < N_DELAY; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_DELAY; i++) begin
                vld_q[i] <= vld_chain[i];
                if (vld_chain[i]) begin
                    dat_q[i] <= dat_chain[i];
                end
            end
        end
    end

    assign vld_o = vld_chain[N_DELAY];
    assign dat_o = dat_chain[N_DELAY];

endmodule

// File: rtl/dpram_be_wrapper.sv
// Dual-port RAM wrapper: byte-enable write port A, pipelined read port B,
// same-address collision policy and a constant-fill init engine.
module dpram_be_wrapper
    import dpram_pkg::*;
#(
    parameter int unsigned   DW       = 64,
    parameter int unsigned   AW       = 8,
    parameter int unsigned   DEPTH    = 256,
    parameter int unsigned   N_DELAY  = 1,
    parameter int unsigned   WR_FIRST = 1,
    parameter logic [DW-1:0] INIT_VAL = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ena,
    input  logic [DW/8-1:0] wea,
    input  logic [AW-1:0]   addra,
    input  logic [DW-1:0]   dia,
    input  logic            enb,
    input  logic [AW-1:0]   addrb,
    output logic [DW-1:0]   dob,
    output logic            dob_vld,
    input  logic            init_req,
    output logic            init_busy,
    output logic            init_done,
    output logic            wr_drop
);

    localparam int unsigned NB      = DW / 8;
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW:0] LAST    = (AW+1)'(DEPTH - 1);

    if (DW % 8 != 0) begin : g_bad_dw
        $error("dpram_be_wrapper: DW must be a multiple of 8");
    end

    logic [DW-1:0] mem_q [DEPTH];

    init_state_e   state_q;
    logic [AW:0]   cnt_q;
    logic          busy_q;
    logic          done_q;
    logic          drop_q;

    logic          wr_req;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [NB-1:0] wr_be;
    logic [DW-1:0] wr_data;
    logic          rd_in_range;
    logic          collide;
    logic [DW-1:0] old_word;
    logic [DW-1:0] coll_word;
    logic [DW-1:0] rd_word;

    // The init engine owns the write port for the whole fill.
    always_comb begin
        wr_req = ena && (|wea);
        if (busy_q) begin
            wr_en   = 1'b1;
            wr_addr = cnt_q[AW-1:0];
            wr_be   = '1;
            wr_data = INIT_VAL;
        end else begin
            wr_en   = wr_req && ({1'b0, addra} < DEPTH_W);
            wr_addr = addra;
            wr_be   = wea;
            wr_data = dia;
        end
    end

    always_comb begin
        rd_in_range = {1'b0, addrb} < DEPTH_W;
        old_word    = rd_in_range ? mem_q[addrb] : '0;
        collide     = wr_en && rd_in_range && (wr_addr == addrb);
        for (int b = 0; b < NB; b++) begin
            coll_word[8*b +: 8] = wr_be[b] ? wr_data[8*b +: 8] : old_word[8*b +: 8];
        end
        rd_word = (collide && (WR_FIRST == COLL_WR_FIRST)) ? coll_word : old_word;
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < NB; b++) begin
                if (wr_be[b]) begin
                    mem_q[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            drop_q <= wr_req && busy_q;
            unique case (state_q)
                IDLE: begin
                    if (init_req) begin
                        state_q <= FILL;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                FILL: begin
                    if (cnt_q == LAST) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    dpram_rd_pipe #(
        .DW      (DW),
        .N_DELAY (N_DELAY)
    ) u_rd_pipe (
        .clk   (clk),
        .rst   (rst),
        .vld_i (enb),
        .dat_i (rd_word),
        .vld_o (dob_vld),
        .dat_o (dob)
    );

    assign init_busy = busy_q;
    assign init_done = done_q;
    assign wr_drop   = drop_q;

endmodule
